bottle_fill_ctrl: RTL and testbench
===================================

# bottle_fill_ctrl

Sequencing controller for the tablet bottling line. It owns the fill cycle for each bottle:
- waits for a bottle at the station;
- opens the dispensing gate and counts tablet pulses up to the set count;
- closes the gate and lets it settle;
- indexes the conveyor, then repeats until the batch is complete.

It sits between the 2 s tick divider, the operator switches/set-count logic and the 7-segment display scanner, and drives the `cur`/`bot_num`/`total` values those consume.

## Interface
- `BATCH`, 18: bottles per batch (1..99).
- `TIMEOUT_TICKS`, 8: ticks allowed in WAIT_BOT or INDEX before a bottle fault.
- `cp`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `tick`  in  1  one-cycle strobe from the tick divider; paces settle and timeouts.
- `start`  in  1  run level; 1 = run, 0 = stop/abort.
- `pause`  in  1  pause level.
- `set_num`  in  7  tablets per bottle; valid range 1..99.
- `tab_pulse`  in  1  one-cycle pulse per tablet passing the drop sensor.
- `bottle_ok`  in  1  bottle present at fill station (already synchronised).
- `gate_open`  out  1  dispensing gate enable.
- `conv_run`  out  1  conveyor motor enable.
- `cur`  out  7  tablets in current bottle.
- `bot_num`  out  7  bottles completed this batch.
- `total`  out  10  tablets dispensed this batch, saturating at 999.
- `green`  out  1  running and not paused.
- `red`  out  1  `~green`.
- `done`  out  1  batch complete.
- `fault`  out  2  0 none, 1 overfill, 2 bottle timeout/lost, 3 stray tablet.
- `state`  out  3  FSM state code, for debug.

## Operation
- **State codes:** IDLE=0, WAIT_BOT=1, FILL=2, CLOSE=3, INDEX=4, DONE=5, FAULT=6.
- **Priority:** `rst_n` > abort (`start`=0) > tablet events > `pause` > tick-driven progress.
- **IDLE**
  - On `start`=1 with `set_num` in 1..99: latch `set_q`=`set_num`, clear `cur`, `bot_num`, `total` and `fault`, then go to WAIT_BOT.
  - `set_num` of 0 or >99: remain in IDLE.
- **WAIT_BOT**
  - `bottle_ok`=1: clear `cur`, go to FILL.
  - `TIMEOUT_TICKS` ticks elapse with no bottle: go to FAULT, code 2.
- **FILL**
  - `gate_open`=1.
  - Each `tab_pulse`: `cur`+1 and `total`+1 (saturating at 999).
  - When the incremented `cur` equals `set_q`: go to CLOSE.
  - `bottle_ok` falls: go to FAULT, code 2.
- **CLOSE**
  - `gate_open`=0. The settle timer waits for the second `tick` after entry.
  - A `tab_pulse` here is an overfill: `cur`/`total` still increment, then go to FAULT, code 1.
  - At the second tick: `bot_num`+1, go to INDEX.
- **INDEX**
  - `conv_run`=1 until `bottle_ok`=0.
  - Then go to DONE if `bot_num`==`BATCH`, else WAIT_BOT.
  - Timeout as in WAIT_BOT.
- **Stray tablets:** a `tab_pulse` in WAIT_BOT or INDEX goes to FAULT, code 3. `tab_pulse` is ignored in IDLE, DONE and FAULT.
- **DONE:** `done`=1, all counts held; on `start`=0, go to IDLE.
- **FAULT:** `gate_open`=`conv_run`=0, counts and `fault` held; on `start`=0, go to IDLE. Only `start` low exits FAULT.
- **Abort:** `start`=0 in any running state goes to IDLE with counts held for display. `fault` is cleared only on the next valid start.
- **Pause:**
  - Forces `gate_open`=`conv_run`=0.
  - Freezes the tick timers and all tick/bottle-driven transitions.
  - Tablet counting, reaching `set_q` (FILL to CLOSE) and overfill detection still act during pause.
- **Counter widths:**
  - `cur` ≤ `set_q`+1 ≤ 100 fits 7 bits.
  - `bot_num` ≤ `BATCH`.
  - Timer is 4 bits; it clears on every state entry.

## Timing
- **Reset:** `state`=IDLE, `cur`=`bot_num`=`total`=0, `gate_open`=`conv_run`=`green`=`done`=0, `red`=1, `fault`=0.
- All outputs are registered: an input sampled at edge N is reflected on the outputs after edge N.
- **Gate closing:** a `tab_pulse` that completes the count drops `gate_open` at the same edge that enters CLOSE.
- `tick` and `tab_pulse` in the same cycle in CLOSE: overfill (FAULT) wins.
- `tick` in the same cycle as any state entry is not counted by the new state's timer.
- `start` falling in the same cycle as a `tab_pulse`: abort wins; the pulse is not counted.
- **Release:** `pause` released restarts the timers from their held values; no tick is lost or added.

## Test plan
- **Nominal batch:** `BATCH`=2, `set_num`=3, `bottle_ok` cycled correctly.
  - `cur` steps 1,2,3 then the gate closes.
  - After 2 ticks, `bot_num`=1, `conv_run`=1.
  - End state: `total`=6, `done`=1, `state`=5.
- **Overfill:** `set_num`=5, a 6th `tab_pulse` arrives in CLOSE before the settle completes.
  - Required: `cur`=6, `fault`=1, `gate_open`=`conv_run`=0, `state`=6.
  - `start`=0 then 1 returns to WAIT_BOT with `fault`=0.
- **No bottle:** no `bottle_ok` for 8 ticks in WAIT_BOT.
  - Required: `fault`=2. Also: `bottle_ok` dropped mid-FILL gives `fault`=2 on the next edge.
- **Pause in FILL at `cur`=2 of 4:**
  - `gate_open`=0 and `green`=0/`red`=1 while paused.
  - 2 pulses during pause give `cur`=4 and the FSM enters CLOSE.
  - The settle does not advance until pause is released.
- **Boundaries and reset:**
  - `set_num`=0 or 100 with `start`=1 stays in IDLE.
  - A stray pulse in INDEX gives `fault`=3.
  - `rst_n` low mid-FILL clears all outputs immediately (asynchronously) to their reset values.

Source files
------------

// File: rtl/bottle_fill_ctrl.sv
// Fill-cycle sequencer for the tablet bottling line: waits for a bottle, gates tablets
// up to the set count, settles, indexes the conveyor and repeats until the batch completes.
module bottle_fill_ctrl #(
  parameter int BATCH         = 18,
  parameter int TIMEOUT_TICKS = 8
) (
  input  logic       cp,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       start,
  input  logic       pause,
  input  logic [6:0] set_num,
  input  logic       tab_pulse,
  input  logic       bottle_ok,
  output logic       gate_open,
  output logic       conv_run,
  output logic [6:0] cur,
  output logic [6:0] bot_num,
  output logic [9:0] total,
  output logic       green,
  output logic       red,
  output logic       done,
  output logic [1:0] fault,
  output logic [2:0] state
);

  // state    | meaning
  // IDLE     | stopped, counts held for display
  // WAIT_BOT | waiting for a bottle at the station, timeout armed
  // FILL     | gate open, counting tablets towards set_q
  // CLOSE    | gate shut, settling for two ticks
  // INDEX    | conveyor moving the full bottle out, timeout armed
  // DONE     | batch complete
  // FAULT    | halted with a fault code until start drops
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_BOT = 3'd1,
    S_FILL     = 3'd2,
    S_CLOSE    = 3'd3,
    S_INDEX    = 3'd4,
    S_DONE     = 3'd5,
    S_FAULT    = 3'd6
  } state_t;

  localparam logic [3:0] TMO_LOAD    = 4'(TIMEOUT_TICKS);
  localparam logic [3:0] SETTLE_LOAD = 4'd2;
  localparam logic [6:0] BATCH_C     = 7'(BATCH);
  localparam logic [9:0] TOTAL_MAX   = 10'd999;

  state_t     state_q, state_d;
  logic [6:0] set_q, set_d;
  logic [6:0] cur_q, cur_d;
  logic [6:0] bot_q, bot_d;
  logic [9:0] total_q, total_d;
  logic [1:0] fault_q, fault_d;
  logic [3:0] timer_q, timer_d;
  logic       gate_q, gate_d;
  logic       conv_q, conv_d;
  logic       green_q, green_d;
  logic       done_q, done_d;
  logic [6:0] cur_inc;
  logic [9:0] total_inc;

  always_ff @(posedge cp or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      set_q   <= 7'd0;
      cur_q   <= 7'd0;
      bot_q   <= 7'd0;
      total_q <= 10'd0;
      fault_q <= 2'd0;
      timer_q <= 4'd0;
      gate_q  <= 1'b0;
      conv_q  <= 1'b0;
      green_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      set_q   <= set_d;
      cur_q   <= cur_d;
      bot_q   <= bot_d;
      total_q <= total_d;
      fault_q <= fault_d;
      timer_q <= timer_d;
      gate_q  <= gate_d;
      conv_q  <= conv_d;
      green_q <= green_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    set_d     = set_q;
    cur_d     = cur_q;
    bot_d     = bot_q;
    total_d   = total_q;
    fault_d   = fault_q;
    timer_d   = timer_q;
    cur_inc   = cur_q + 7'd1;
    total_inc = (total_q == TOTAL_MAX) ? total_q : total_q + 10'd1;

    case (state_q)
      S_IDLE: begin
        if (start && set_num != 7'd0 && set_num <= 7'd99) begin
          set_d   = set_num;
          cur_d   = 7'd0;
          bot_d   = 7'd0;
          total_d = 10'd0;
          fault_d = 2'd0;
          state_d = S_WAIT_BOT;
        end
      end
      S_WAIT_BOT: begin
        if (!start) begin
          state_d = S_IDLE;
        end else if (tab_pulse) begin
          fault_d = 2'd3;
          state_d = S_FAULT;
        end else if (!pause) begin
          if (bottle_ok) begin
            cur_d   = 7'd0;
            state_d = S_FILL;
          end else if (tick) begin
            if (timer_q == 4'd1) begin
              fault_d = 2'd2;
              state_d = S_FAULT;
            end else begin
              timer_d = timer_q - 4'd1;
            end
          end
        end
      end
      S_FILL: begin
        if (!start) begin
          state_d = S_IDLE;
        end else begin
          if (tab_pulse) begin
            cur_d   = cur_inc;
            total_d = total_inc;
          end
          // Reaching the count is a tablet event, so it beats a bottle loss in the same cycle.
          if (tab_pulse && cur_inc == set_q) begin
            state_d = S_CLOSE;
          end else if (!pause && !bottle_ok) begin
            fault_d = 2'd2;
            state_d = S_FAULT;
          end
        end
      end
      S_CLOSE: begin
        if (!start) begin
          state_d = S_IDLE;
        end else if (tab_pulse) begin
          cur_d   = cur_inc;
          total_d = total_inc;
          fault_d = 2'd1;
          state_d = S_FAULT;
        end else if (!pause && tick) begin
          if (timer_q == 4'd1) begin
            bot_d   = bot_q + 7'd1;
            state_d = S_INDEX;
          end else begin
            timer_d = timer_q - 4'd1;
          end
        end
      end
      S_INDEX: begin
        if (!start) begin
          state_d = S_IDLE;
        end else if (tab_pulse) begin
          fault_d = 2'd3;
          state_d = S_FAULT;
        end else if (!pause) begin
          if (!bottle_ok) begin
            state_d = (bot_q == BATCH_C) ? S_DONE : S_WAIT_BOT;
          end else if (tick) begin
            if (timer_q == 4'd1) begin
              fault_d = 2'd2;
              state_d = S_FAULT;
            end else begin
              timer_d = timer_q - 4'd1;
            end
          end
        end
      end
      S_DONE, S_FAULT: begin
        if (!start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Loading on entry also discards a tick that coincides with the transition.
    if (state_d != state_q) begin
      timer_d = (state_d == S_CLOSE) ? SETTLE_LOAD : TMO_LOAD;
    end
  end

  always_comb begin
    gate_d  = (state_d == S_FILL) && !pause;
    conv_d  = (state_d == S_INDEX) && !pause;
    green_d = (state_d == S_WAIT_BOT || state_d == S_FILL ||
               state_d == S_CLOSE || state_d == S_INDEX) && !pause;
    done_d  = (state_d == S_DONE);
  end

  assign gate_open = gate_q;
  assign conv_run  = conv_q;
  assign cur       = cur_q;
  assign bot_num   = bot_q;
  assign total     = total_q;
  assign green     = green_q;
  assign red       = ~green_q;
  assign done      = done_q;
  assign fault     = fault_q;
  assign state     = state_q;

endmodule

// File: tb/tb_bottle_fill_ctrl.sv
// Directed bench for bottle_fill_ctrl with a two-bottle batch and an 8-tick timeout.
module tb_bottle_fill_ctrl;

  logic       cp = 1'b0;
  logic       rst_n;
  logic       tick;
  logic       start;
  logic       pause;
  logic [6:0] set_num;
  logic       tab_pulse;
  logic       bottle_ok;
  logic       gate_open;
  logic       conv_run;
  logic [6:0] cur;
  logic [6:0] bot_num;
  logic [9:0] total;
  logic       green;
  logic       red;
  logic       done;
  logic [1:0] fault;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  bottle_fill_ctrl #(.BATCH(2), .TIMEOUT_TICKS(8)) dut (
    .cp        (cp),
    .rst_n     (rst_n),
    .tick      (tick),
    .start     (start),
    .pause     (pause),
    .set_num   (set_num),
    .tab_pulse (tab_pulse),
    .bottle_ok (bottle_ok),
    .gate_open (gate_open),
    .conv_run  (conv_run),
    .cur       (cur),
    .bot_num   (bot_num),
    .total     (total),
    .green     (green),
    .red       (red),
    .done      (done),
    .fault     (fault),
    .state     (state)
  );

  always #5 cp = ~cp;

  task automatic step();
    @(posedge cp);
    #1;
  endtask

  task automatic pulse();
    tab_pulse = 1'b1;
    step();
    tab_pulse = 1'b0;
  endtask

  task automatic tick_once();
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; tick = 1'b0; start = 1'b0; pause = 1'b0;
    set_num = 7'd0; tab_pulse = 1'b0; bottle_ok = 1'b0;
    #12;
    chk("rst_state", 32'(state), 0);
    chk("rst_red", 32'(red), 1);
    chk("rst_green", 32'(green), 0);
    chk("rst_total", 32'(total), 0);
    chk("rst_fault", 32'(fault), 0);
    rst_n = 1'b1;
    step();

    // Nominal two-bottle batch, three tablets each
    set_num = 7'd3; start = 1'b1;
    step();
    chk("nom_wait", 32'(state), 1);
    chk("nom_green", 32'(green), 1);
    bottle_ok = 1'b1;
    step();
    chk("nom_fill", 32'(state), 2);
    chk("nom_gate", 32'(gate_open), 1);
    pulse();
    chk("nom_cur1", 32'(cur), 1);
    pulse();
    chk("nom_cur2", 32'(cur), 2);
    pulse();
    chk("nom_cur3", 32'(cur), 3);
    chk("nom_close", 32'(state), 3);
    chk("nom_gate_shut", 32'(gate_open), 0);
    tick_once();
    chk("nom_settle1", 32'(state), 3);
    tick_once();
    chk("nom_index", 32'(state), 4);
    chk("nom_bot1", 32'(bot_num), 1);
    chk("nom_conv", 32'(conv_run), 1);
    bottle_ok = 1'b0;
    step();
    chk("nom_wait2", 32'(state), 1);
    bottle_ok = 1'b1;
    step();
    pulse(); pulse(); pulse();
    tick_once(); tick_once();
    chk("nom_bot2", 32'(bot_num), 2);
    bottle_ok = 1'b0;
    step();
    chk("nom_done_state", 32'(state), 5);
    chk("nom_done", 32'(done), 1);
    chk("nom_total", 32'(total), 6);
    start = 1'b0;
    step();
    chk("nom_abort_idle", 32'(state), 0);
    chk("nom_held_total", 32'(total), 6);

    // Overfill: sixth tablet arrives together with the second settle tick
    set_num = 7'd5; start = 1'b1;
    step();
    chk("ovf_cleared_total", 32'(total), 0);
    bottle_ok = 1'b1;
    step();
    pulse(); pulse(); pulse(); pulse(); pulse();
    chk("ovf_close", 32'(state), 3);
    tick_once();
    tick = 1'b1; tab_pulse = 1'b1;
    step();
    tick = 1'b0; tab_pulse = 1'b0;
    chk("ovf_state", 32'(state), 6);
    chk("ovf_cur", 32'(cur), 6);
    chk("ovf_fault", 32'(fault), 1);
    chk("ovf_gate", 32'(gate_open), 0);
    chk("ovf_conv", 32'(conv_run), 0);
    chk("ovf_bot", 32'(bot_num), 0);
    start = 1'b0; bottle_ok = 1'b0;
    step();
    chk("ovf_fault_held", 32'(fault), 1);
    start = 1'b1;
    step();
    chk("ovf_restart", 32'(state), 1);
    chk("ovf_fault_clr", 32'(fault), 0);

    // No bottle for eight ticks
    for (int i = 0; i < 7; i++) tick_once();
    chk("nob_still_wait", 32'(state), 1);
    tick_once();
    chk("nob_fault", 32'(fault), 2);
    chk("nob_state", 32'(state), 6);

    // Bottle lost mid-fill
    start = 1'b0;
    step();
    start = 1'b1;
    step();
    bottle_ok = 1'b1;
    step();
    pulse();
    bottle_ok = 1'b0;
    step();
    chk("lost_state", 32'(state), 6);
    chk("lost_fault", 32'(fault), 2);

    // Pause in fill at cur=2 of 4
    start = 1'b0;
    step();
    set_num = 7'd4; start = 1'b1;
    step();
    bottle_ok = 1'b1;
    step();
    pulse(); pulse();
    pause = 1'b1;
    step();
    chk("pse_gate", 32'(gate_open), 0);
    chk("pse_green", 32'(green), 0);
    chk("pse_red", 32'(red), 1);
    pulse(); pulse();
    chk("pse_cur", 32'(cur), 4);
    chk("pse_close", 32'(state), 3);
    tick_once(); tick_once(); tick_once();
    chk("pse_frozen", 32'(state), 3);
    pause = 1'b0;
    step();
    chk("pse_green_back", 32'(green), 1);
    tick_once();
    chk("pse_settle1", 32'(state), 3);
    tick_once();
    chk("pse_index", 32'(state), 4);
    chk("pse_bot", 32'(bot_num), 1);

    // Stray tablet in INDEX
    pulse();
    chk("stray_state", 32'(state), 6);
    chk("stray_fault", 32'(fault), 3);

    // Invalid set counts keep IDLE
    start = 1'b0; bottle_ok = 1'b0;
    step();
    set_num = 7'd0; start = 1'b1;
    step();
    chk("set0_idle", 32'(state), 0);
    set_num = 7'd100;
    step();
    chk("set100_idle", 32'(state), 0);
    chk("set100_fault_held", 32'(fault), 3);

    // Abort beats a tablet in the same cycle
    set_num = 7'd3;
    step();
    bottle_ok = 1'b1;
    step();
    chk("abt_fill", 32'(state), 2);
    start = 1'b0; tab_pulse = 1'b1;
    step();
    tab_pulse = 1'b0;
    chk("abt_idle", 32'(state), 0);
    chk("abt_cur", 32'(cur), 0);

    // Asynchronous reset mid-fill
    start = 1'b1;
    step();
    step();
    pulse();
    chk("arst_pre_cur", 32'(cur), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_state", 32'(state), 0);
    chk("arst_cur", 32'(cur), 0);
    chk("arst_total", 32'(total), 0);
    chk("arst_gate", 32'(gate_open), 0);
    chk("arst_red", 32'(red), 1);
    rst_n = 1'b1;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
